// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce/synchronizer block.
// State encoding and the level/busy decodes live here so other blocks agree on them.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      CHK_HI  = 2'd1,
      IDLE_HI = 2'd2,
      CHK_LO  = 2'd3
   } db_state_t;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_CNT_W       = 16;
   localparam int DEF_STABLE_CNT  = 1000;

   function automatic logic state_level(input db_state_t s);
      logic lvl;
      case (s)
         IDLE_HI: lvl = 1'b1;
         CHK_LO:  lvl = 1'b1;
         IDLE_LO: lvl = 1'b0;
         CHK_HI:  lvl = 1'b0;
         default: lvl = 1'b0;
      endcase
      return lvl;
   endfunction

   function automatic logic state_busy(input db_state_t s);
      logic bsy;
      case (s)
         CHK_HI:  bsy = 1'b1;
         CHK_LO:  bsy = 1'b1;
         IDLE_LO: bsy = 1'b0;
         IDLE_HI: bsy = 1'b0;
         default: bsy = 1'b0;
      endcase
      return bsy;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Generic multi-flop synchronizer for a single asynchronous bit.
// Only q (the last stage) is safe to use in the clk domain.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_r;

   // shift the raw input through the metastability chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_r <= {STAGES{1'b0}};
      end else begin
         chain_r <= {chain_r[STAGES-2:0], d};
      end
   end

   assign q = chain_r[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes a raw pin and accepts a new level only after STABLE_CNT
// consecutive enabled samples agree; emits registered level/rise/fall/busy.
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int STABLE_CNT  = DEF_STABLE_CNT
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   input  logic en,
   output logic level,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] STABLE_VAL = CNT_W'(STABLE_CNT);

   logic             sync_s;
   db_state_t        state_r;
   db_state_t        state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             level_r;
   logic             rise_r;
   logic             fall_r;
   logic             busy_r;
   logic             level_nxt_s;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (sync_s)
   );

   // next-state and counter logic; nothing moves on cycles without en
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      cnt_inc_s   = cnt_r + CNT_ONE;
      if (en) begin
         case (state_r)
            IDLE_LO: begin
               if (sync_s) begin
                  if (STABLE_VAL == CNT_ONE) begin
                     state_nxt_s = IDLE_HI;
                     cnt_nxt_s   = CNT_ZERO;
                  end else begin
                     state_nxt_s = CHK_HI;
                     cnt_nxt_s   = CNT_ONE;
                  end
               end else begin
                  state_nxt_s = IDLE_LO;
               end
            end
            CHK_HI: begin
               if (sync_s) begin
                  if (cnt_inc_s == STABLE_VAL) begin
                     state_nxt_s = IDLE_HI;
                     cnt_nxt_s   = CNT_ZERO;
                  end else begin
                     cnt_nxt_s   = cnt_inc_s;
                  end
               end else begin
                  state_nxt_s = IDLE_LO;
                  cnt_nxt_s   = CNT_ZERO;
               end
            end
            IDLE_HI: begin
               if (!sync_s) begin
                  if (STABLE_VAL == CNT_ONE) begin
                     state_nxt_s = IDLE_LO;
                     cnt_nxt_s   = CNT_ZERO;
                  end else begin
                     state_nxt_s = CHK_LO;
                     cnt_nxt_s   = CNT_ONE;
                  end
               end else begin
                  state_nxt_s = IDLE_HI;
               end
            end
            CHK_LO: begin
               if (!sync_s) begin
                  if (cnt_inc_s == STABLE_VAL) begin
                     state_nxt_s = IDLE_LO;
                     cnt_nxt_s   = CNT_ZERO;
                  end else begin
                     cnt_nxt_s   = cnt_inc_s;
                  end
               end else begin
                  state_nxt_s = IDLE_HI;
                  cnt_nxt_s   = CNT_ZERO;
               end
            end
            default: begin
               state_nxt_s = IDLE_LO;
               cnt_nxt_s   = CNT_ZERO;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
         cnt_nxt_s   = cnt_r;
      end
   end

   // outputs are decoded from the next state so they update on the same edge as state
   assign level_nxt_s = state_level(state_nxt_s);

   // state, counter and registered output flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE_LO;
         cnt_r   <= CNT_ZERO;
         level_r <= 1'b0;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         level_r <= level_nxt_s;
         rise_r  <= level_nxt_s & ~level_r;
         fall_r  <= ~level_nxt_s & level_r;
         busy_r  <= state_busy(state_nxt_s);
      end
   end

   assign level = level_r;
   assign rise  = rise_r;
   assign fall  = fall_r;
   assign busy  = busy_r;

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: STABLE_CNT=4 and STABLE_CNT=1 instances,
// directed stimulus pushes expected pulses/levels, a negedge monitor checks them.
module tb_debounce_sync;

   logic clk;
   logic rst;
   logic din;
   logic din1;
   logic en;
   logic level, rise, fall, busy;
   logic level1, rise1, fall1, busy1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   debounce_sync #(.SYNC_STAGES(2), .CNT_W(16), .STABLE_CNT(4)) dut (
      .clk(clk), .rst(rst), .din(din), .en(en),
      .level(level), .rise(rise), .fall(fall), .busy(busy)
   );

   debounce_sync #(.SYNC_STAGES(2), .CNT_W(16), .STABLE_CNT(1)) dut1 (
      .clk(clk), .rst(rst), .din(din1), .en(en),
      .level(level1), .rise(rise1), .fall(fall1), .busy(busy1)
   );

   typedef struct {int cy; int sig; logic val;} exp_t;
   typedef struct {int cy; logic up;} ev_t;

   exp_t exq[$];
   ev_t  evq[$];
   ev_t  ev1q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string sig_name(input int sig);
      case (sig)
         0: return "level";
         1: return "busy";
         2: return "rise";
         3: return "fall";
         4: return "level1";
         5: return "busy1";
         default: return "unknown";
      endcase
   endfunction

   function automatic logic pick(input int sig);
      case (sig)
         0: return level;
         1: return busy;
         2: return rise;
         3: return fall;
         4: return level1;
         5: return busy1;
         default: return 1'bx;
      endcase
   endfunction

   task automatic cmp(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
      end
   endtask

   task automatic ex(input int cy, input int sig, input logic v);
      exp_t e;
      e.cy = cy; e.sig = sig; e.val = v;
      exq.push_back(e);
   endtask

   task automatic ev(input int cy, input logic up);
      ev_t e;
      e.cy = cy; e.up = up;
      evq.push_back(e);
   endtask

   task automatic ev1(input int cy, input logic up);
      ev_t e;
      e.cy = cy; e.up = up;
      ev1q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // monitor: point expectations, pulse scoreboard, end-of-run drain
   always @(negedge clk) begin
      ev_t e;
      for (int i = exq.size() - 1; i >= 0; i--) begin
         if (exq[i].cy == cyc) begin
            cmp(sig_name(exq[i].sig), int'(pick(exq[i].sig)), int'(exq[i].val));
            exq.delete(i);
         end
      end
      cmp("rise_and_fall_together", int'(rise & fall), 0);
      cmp("rise1_and_fall1_together", int'(rise1 & fall1), 0);
      if (rise | fall) begin
         if (evq.size() == 0) begin
            cmp("unexpected_pulse", int'(rise), 2);
         end else begin
            e = evq.pop_front();
            cmp("pulse_cycle", cyc, e.cy);
            cmp("pulse_is_rise", int'(rise), int'(e.up));
            cmp("pulse_level", int'(level), int'(e.up));
         end
      end
      if (rise1 | fall1) begin
         if (ev1q.size() == 0) begin
            cmp("unexpected_pulse1", int'(rise1), 2);
         end else begin
            e = ev1q.pop_front();
            cmp("pulse1_cycle", cyc, e.cy);
            cmp("pulse1_is_rise", int'(rise1), int'(e.up));
            cmp("pulse1_level", int'(level1), int'(e.up));
         end
      end
      if (done) begin
         cmp("pending_expectations", exq.size() + evq.size() + ev1q.size(), 0);
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, expected finish before 100000");
      $fatal(1);
   end

   initial begin
      int c;
      rst = 1'b1; din = 1'b1; din1 = 1'b0; en = 1'b1;

      // reset values, then first rise counted from the first post-reset edge
      tick(2);
      c = cyc;
      for (int s = 0; s < 6; s++) ex(c + 1, s, 1'b0);
      ex(c + 1, 2, 1'b0);
      tick(1);
      c = cyc; rst = 1'b0;
      ex(c + 3, 1, 1'b1); ex(c + 5, 0, 1'b0); ev(c + 6, 1'b1);
      ex(c + 6, 0, 1'b1); ex(c + 6, 1, 1'b0); ex(c + 7, 2, 1'b0);
      tick(8);

      // clean fall
      c = cyc; din = 1'b0;
      ex(c + 5, 0, 1'b1); ev(c + 6, 1'b0); ex(c + 6, 0, 1'b0); ex(c + 7, 3, 1'b0);
      tick(8);

      // clean rise
      c = cyc; din = 1'b1;
      ex(c + 3, 1, 1'b1); ev(c + 6, 1'b1); ex(c + 7, 2, 1'b0);
      tick(8);

      // fall with a 1-0-1 bounce restarting the count
      c = cyc; din = 1'b0;
      ex(c + 3, 1, 1'b1); ex(c + 4, 1, 1'b0); ex(c + 5, 1, 1'b1);
      ex(c + 7, 0, 1'b1); ev(c + 8, 1'b0); ex(c + 8, 0, 1'b0);
      tick(1); din = 1'b1;
      tick(1); din = 1'b0;
      tick(8);

      // two-cycle glitch: busy pulses, no rise
      c = cyc; din = 1'b1;
      ex(c + 3, 1, 1'b1); ex(c + 4, 1, 1'b1); ex(c + 5, 1, 1'b0); ex(c + 6, 0, 1'b0);
      tick(2); din = 1'b0;
      tick(8);

      // async reset in the middle of a qualification, then restart from zero
      c = cyc; din = 1'b1;
      ex(c + 3, 1, 1'b1); ex(c + 4, 1, 1'b0); ex(c + 4, 0, 1'b0);
      ex(c + 4, 2, 1'b0); ex(c + 4, 3, 1'b0);
      tick(3);
      #6 rst = 1'b1;
      tick(3);
      c = cyc; rst = 1'b0;
      ex(c + 3, 1, 1'b1); ex(c + 5, 0, 1'b0); ev(c + 6, 1'b1);
      tick(8);

      // back to low, then gated sampling with en every 4th cycle
      c = cyc; din = 1'b0;
      ev(c + 6, 1'b0);
      tick(8);
      c = cyc; din = 1'b1;
      ex(c + 4, 1, 1'b1); ex(c + 12, 0, 1'b0); ex(c + 15, 0, 1'b0);
      ex(c + 15, 1, 1'b1); ev(c + 16, 1'b1); ex(c + 16, 0, 1'b1);
      for (int k = 0; k < 18; k++) begin
         en = (k % 4 == 3);
         tick(1);
      end
      en = 1'b1;
      tick(2);

      // STABLE_CNT=1 instance: follows after two sync edges, never busy
      c = cyc; din1 = 1'b1;
      ex(c + 2, 4, 1'b0); ex(c + 2, 5, 1'b0); ev1(c + 3, 1'b1);
      ex(c + 3, 4, 1'b1); ex(c + 3, 5, 1'b0);
      tick(5);
      c = cyc; din1 = 1'b0;
      ex(c + 2, 5, 1'b0); ex(c + 2, 4, 1'b1); ev1(c + 3, 1'b0); ex(c + 3, 4, 1'b0);
      tick(5);

      done = 1'b1;
      tick(4);
   end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop count, legal range 2..4.
REQ-002 SHALL have parameter CNT_W, default 16: stability counter width.
REQ-003 SHALL have parameter STABLE_CNT, default 1000: consecutive enabled samples required to accept a new level, legal range 1..2^CNT_W-1.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port din, input, 1: raw asynchronous input (switch/pin).
REQ-007 SHALL have port en, input, 1: sample enable (prescaler tick); tie high to sample every cycle.
REQ-008 SHALL have port level, output, 1: debounced registered level; feeds downstream d_ff data inputs.
REQ-009 SHALL have port rise, output, 1: one-cycle pulse on an accepted 0->1 transition.
REQ-010 SHALL have port fall, output, 1: one-cycle pulse on an accepted 1->0 transition.
REQ-011 SHALL have port busy, output, 1: high while a candidate transition is being qualified.

Function
REQ-012 SHALL pass din through a SYNC_STAGES-deep flop chain; only the last stage (sync) is used by the rest of the logic.
REQ-013 SHALL implement an FSM with states IDLE_LO, CHK_HI, IDLE_HI and CHK_LO.
REQ-014 In IDLE_LO, with en=1 and sync=1: go to IDLE_HI if STABLE_CNT=1, otherwise go to CHK_HI with cnt=1; all other cases hold.
REQ-015 In CHK_HI, with en=1 and sync=1: increment cnt; when the incremented value equals STABLE_CNT, go to IDLE_HI and clear cnt.
REQ-016 In CHK_HI, with en=1 and sync=0: return to IDLE_LO and clear cnt; no pulse, level unchanged.
REQ-017 IDLE_HI and CHK_LO SHALL mirror REQ-014..016 with polarity inverted.
REQ-018 With en=0, SHALL hold both state and cnt regardless of sync.
REQ-019 level SHALL be 1 exactly in IDLE_HI and CHK_LO, and SHALL be registered, not decoded combinationally from sync.
REQ-020 rise/fall SHALL assert for exactly one clk cycle, in the same cycle level changes; they never assert together.
REQ-021 busy SHALL be 1 exactly in CHK_HI and CHK_LO.
REQ-022 Latency with en=1: din changes before edge E0 and stays stable -> level changes after edge E0+SYNC_STAGES+STABLE_CNT-1.
REQ-023 cnt SHALL never exceed STABLE_CNT and SHALL never wrap.

Reset
REQ-024 rst SHALL clear all state asynchronously: sync chain 0, state IDLE_LO, cnt 0, level 0, rise 0, fall 0, busy 0.
REQ-025 Reset asserted mid-qualification SHALL abandon the candidate without emitting a pulse.
REQ-026 After rst deasserts with din=1, the first rise SHALL occur per REQ-022, counted from the first post-reset edge.

Structure
REQ-027 Package debounce_pkg SHALL hold the FSM state typedef and the default parameter constants.
REQ-028 The flop chain SHALL be a separate sub-module, sync_chain (parameter STAGES, ports clk/rst/d/q), reusable across the codebase.
REQ-029 The FSM, counter and output registers SHALL reside in debounce_sync.

Verification (SYNC_STAGES=2, STABLE_CNT=4, en=1 unless stated)
REQ-030 Clean step: din 0->1 before E0 -> level=1 and rise=1 after E5; rise low after E6; fall stays 0.
REQ-031 Glitch: din high for 2 cycles, then low -> busy pulses high, level stays 0, no rise.
REQ-032 Gated sampling: en high every 4th cycle, din held at 1 -> level rises after the 4th enabled sample following sync=1, not before.
REQ-033 Reset mid-check: rst asserted while busy=1, cnt=2 -> all outputs 0 immediately (asynchronously), no pulse; after release, qualification restarts from cnt=0.
REQ-034 Fall path: from level=1, din 1->0 -> level=0 and fall=1 after E5; a bounce 1-0-1 inside the window restarts the count.
REQ-035 STABLE_CNT=1 build: din step -> level follows after E0+2 with a single rise; CHK states never entered (busy stays 0).
